synfifo_param: RTL
==================

Name: synfifo_param

Overview:
Parametrised single-clock FIFO and the next generation of the team's 8x16 synchronous FIFO. Adds:
- configurable width and depth
- occupancy count
- programmable almost-full and almost-empty flags
- a registered read-valid strobe
- sticky overflow and underflow error flags
- an optional first-word-fall-through read mode

It is used as the general-purpose buffer between producer and consumer stages in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
ADDR_W (localparam), $clog2(DEPTH), memory address width

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
wr_en  input  1  write request
data_in  input  DATA_W  write data
rd_en  input  1  read request (pop acknowledge in FWFT mode)
err_clr  input  1  clears overflow/underflow
data_out  output  DATA_W  read data
data_valid  output  1  data_out holds a newly read word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write rejected because FIFO was full
underflow  output  1  sticky: read rejected because FIFO was empty

Behaviour:
- Pointers: wr_ptr and rd_ptr, each binary and ADDR_W+1 bits wide; the MSB is the wrap bit.
  - Memory is addressed by ptr[ADDR_W-1:0].
  - Natural modulo-2^(ADDR_W+1) wrap; no explicit compare-and-reset.
- Status flags:
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal and wrap bits differ.
  - count = wr_ptr - rd_ptr, taken modulo 2^(ADDR_W+1).
  - All status flags are combinational decodes of the registered pointers only; none depends on the current-cycle wr_en or rd_en.
- Accept rules:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_acc): write on full is allowed only when a read is accepted in the same cycle.
- Simultaneous accesses:
  - Full with wr_en and rd_en: both accepted; count stays DEPTH; full stays 1.
  - Empty with wr_en and rd_en: write accepted, read rejected; underflow sets; next cycle count = 1.
- Memory: written at the clk edge when wr_acc, at mem[wr_ptr[ADDR_W-1:0]]. The memory is not reset.
- Read path, standard mode (macro undefined):
  - On rd_acc, data_out <= mem[rd_addr] and data_valid <= 1. Latency is one cycle from the rd_en edge.
  - Without rd_acc, data_valid <= 0 and data_out holds its last value (it is not zeroed).
- Errors:
  - overflow sets on wr_en & !wr_acc; underflow sets on rd_en & !rd_acc.
  - Both hold until err_clr or rst.
  - An error event in the same cycle as err_clr leaves the flag set (set wins).
- Reset (rst=1 at an edge): pointers = 0, data_out = 0, data_valid = 0, overflow = underflow = 0.
  - Resulting outputs: empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0 ? 1 : 0), which resolves to 0 for the legal range.
  - Reset mid-operation discards all contents immediately; any wr_en or rd_en in the reset cycle is ignored.
- Elaboration check: the design must fail elaboration if DEPTH is not a power of two or if AF_LEVEL/AE_LEVEL are out of range.

Optional Feature:
Macro SYNFIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr[ADDR_W-1:0]] combinationally.
  - data_valid = !empty.
  - A word written at edge k is visible on data_out with data_valid = 1 right after edge k.
  - rd_en with data_valid = 1 pops the head word; the next word appears after that edge.
  - Reading while empty sets underflow.
  - data_out is undefined while data_valid = 0.
- Undefined: standard registered read mode as described above.

Test Plan:
- Reset, then write 0x01..0x10 (16 words, DEPTH=16, DATA_W=8) -> count steps 1..16. almost_full rises at count 14. full=1 after the 16th write; empty=0 throughout.
- Read 16 words from full -> data_out 0x01..0x10, each one cycle after rd_en with data_valid=1. almost_empty rises at count 2. empty=1 after the last read. A 17th rd_en sets underflow=1, data_valid=0, and data_out holds 0x10.
- Full FIFO, wr_en=rd_en=1 with data_in=0xAA for 20 cycles -> full stays 1, count stays 16, overflow stays 0. Pointers wrap past 31->0; the read sequence stays in order.
- Full FIFO, wr_en=1 with rd_en=0 -> overflow=1 and contents unchanged. Then err_clr=1 together with another full write -> overflow remains 1. err_clr alone -> overflow=0.
- Write 5 words, assert rst for one cycle alongside wr_en=1 -> count=0, empty=1, data_valid=0, data_out=0x00. The next write then read returns the new word only.
- SYNFIFO_FWFT_EN defined: write 0x3C into an empty FIFO -> the next cycle shows data_valid=1 and data_out=0x3C with no rd_en. Then rd_en=1 for one cycle -> empty=1, data_valid=0.

Source files
------------

// File: rtl/synfifo_param.sv
// synfifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full / almost-empty thresholds, a registered read-valid
// strobe and sticky overflow / underflow flags.
//
// Build option: define SYNFIFO_FWFT_EN for first-word-fall-through reads
// (data_out shows the head word combinationally, data_valid = !empty).
// Without the macro, reads are registered with one cycle of latency.
//
// Handshake: a write is taken on a rising edge where wr_en=1 and the FIFO is
// not full, or is full but a read is taken on the same edge. A read is taken
// on a rising edge where rd_en=1 and the FIFO is not empty. Requests that are
// not taken are dropped (no back-pressure stall) and raise the matching
// sticky error flag until err_clr or rst.
module synfifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_W-1:0]             data_out,
    output logic                          data_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

    // Reject illegal configurations at elaboration time.
    if (DATA_W < 1) begin : g_bad_width
        $error("synfifo_param: DATA_W must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("synfifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("synfifo_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("synfifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [PTR_W-1:0]  count_w;
    logic              empty_w;
    logic              full_w;
    logic              rd_acc;
    logic              wr_acc;

    // Status decode from the registered pointers only; the MSB is the wrap bit.
    always_comb begin
        wr_addr = wr_ptr_q[ADDR_W-1:0];
        rd_addr = rd_ptr_q[ADDR_W-1:0];
        count_w = wr_ptr_q - rd_ptr_q;
        empty_w = (wr_ptr_q == rd_ptr_q);
        full_w  = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
        rd_acc  = rd_en && !empty_w;
        wr_acc  = wr_en && (!full_w || rd_acc);
    end

    // Next-state for pointers and sticky error flags (a new error beats err_clr).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr_en && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (rd_en && !rd_acc) begin
            unf_d = 1'b1;
        end
    end

    // Pointer and error-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; contents are not reset, writes in a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_addr] <= data_in;
        end
    end

`ifdef SYNFIFO_FWFT_EN
    // Head word falls through; it is meaningful only while data_valid is high.
    always_comb begin
        data_out   = mem_q[rd_addr];
        data_valid = !empty_w;
    end
`else
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;

    // Registered read: capture the head word on an accepted read, else hold it.
    always_comb begin
        dout_d   = dout_q;
        dvalid_d = rd_acc;
        if (rd_acc) begin
            dout_d = mem_q[rd_addr];
        end
    end

    // Read-data and read-valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    // Drive the read port from the registers.
    always_comb begin
        data_out   = dout_q;
        data_valid = dvalid_q;
    end
`endif

    // Drive the status and error outputs.
    always_comb begin
        full         = full_w;
        empty        = empty_w;
        count        = count_w;
        almost_full  = (count_w >= AF_THR);
        almost_empty = (count_w <= AE_THR);
        overflow     = ovf_q;
        underflow    = unf_q;
    end

endmodule
